// File: rtl/bram_core.sv
// bram_core: single-port synchronous block RAM with a post-reset clear sequencer.
// Reads return data one cycle after read_i. Writes land on the same edge.
// After every reset the sequencer writes INIT_VALUE to every word, one word per cycle.
// While that clear runs, writes are dropped and reads return INIT_VALUE.
// Define MEM_PARITY_EN to store one even-parity bit per byte and to flag parity errors
// on reads. The port list is the same whether or not the macro is defined.
//
// Handshake: there is no back-pressure. A read is accepted on any rising edge where
// read_i=1 and write_i=0. Its data appears on read_data_o after that edge and stays
// there until the next accepted read. A write is accepted on any READY edge where
// write_i=1. When read_i and write_i are both high, the write happens and the read
// is treated as absent.
module bram_core #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  busy_o,
  input  logic                  inject_i,
  output logic                  parity_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // state_q is the observable FSM state for checkers
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Even parity of each byte of a word
  function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  // FSM state and clear counter; the counter stops at the last address, never wraps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, and a write-port mux that selects the clear sequencer or the user write
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = write_data_i;
    rd_en     = read_i & ~write_i;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VALUE;
      if (cnt_q == LAST_ADDR) state_d = ST_READY;
      else                    cnt_d   = cnt_q + 1'b1;
    end else if (write_i) begin
      mem_we = 1'b1;
    end
  end

  assign busy_o = (state_q == ST_CLEAR);

  // Data array write port; contents are not reset, the clear sequencer initialises them
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          mem_winj;

  // Injection only applies to user writes, never to the clear
  assign mem_winj = (state_q == ST_READY) & inject_i;

  // Parity array write port; injection flips the byte-0 parity bit
  always_ff @(posedge clk_i) begin
    if (mem_we) par_mem[mem_waddr] <= byte_par(mem_wdata) ^ NB'(mem_winj);
  end

  // Registered read data and parity check; both update only on an accepted read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o  <= '0;
      parity_err_o <= 1'b0;
    end else if (rd_en) begin
      if (state_q == ST_CLEAR) begin
        read_data_o  <= INIT_VALUE;
        parity_err_o <= 1'b0;
      end else begin
        read_data_o  <= mem[addr_i];
        parity_err_o <= |(byte_par(mem[addr_i]) ^ par_mem[addr_i]);
      end
    end
  end
`else
  logic unused_inject;
  assign unused_inject = inject_i;
  assign parity_err_o  = 1'b0;

  // Registered read data; updates only on an accepted read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o <= '0;
    end else if (rd_en) begin
      if (state_q == ST_CLEAR) read_data_o <= INIT_VALUE;
      else                     read_data_o <= mem[addr_i];
    end
  end
`endif

endmodule
